depth_test: RTL and testbench

DEPTH_TEST -- requirements
Module: depth_test

---
 rtl/gfx_pkg.sv | 29 ++
 rtl/depth_test_if.sv | 60 ++++++
 rtl/depth_ram.sv | 29 ++
 rtl/depth_test.sv | 180 ++++++++++++++++++
 tb/tb_depth_test.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/gfx_pkg.sv
// Shared graphics definitions: bus widths, the far-plane depth and the
// depth-test state type.
package gfx_pkg;

    localparam logic [63:0] ZFAR = '1;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int f_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int f_hwidth(input int hres);
        return f_width(hres);
    endfunction

    function automatic int f_vwidth(input int vres);
        return f_width(vres);
    endfunction

    function automatic int f_awidth(input int hres, input int vres);
        return f_width(hres * vres);
    endfunction

endpackage

// File: rtl/depth_test_if.sv
// Pixel stream into and out of the depth test, plus the clear handshake.
// DEPTH_TEST_STATS_EN adds the pass/fail counter outputs.
interface depth_test_if #(
    parameter int FB_HRES = 320,
    parameter int FB_VRES = 180,
    parameter int ZWIDTH  = 16
);
    import gfx_pkg::*;

    localparam int HWIDTH = f_hwidth(FB_HRES);
    localparam int VWIDTH = f_vwidth(FB_VRES);
    localparam int AWIDTH = f_awidth(FB_HRES, FB_VRES);

    logic              valid_in;
    logic              ready_out;
    logic [HWIDTH-1:0] hcount_in;
    logic [VWIDTH-1:0] vcount_in;
    logic [ZWIDTH-1:0] z_in;
    logic [AWIDTH-1:0] addr_in;
    logic              clear_in;
    logic              valid_out;
    logic              ready_in;
    logic [HWIDTH-1:0] hcount_out;
    logic [VWIDTH-1:0] vcount_out;
    logic [ZWIDTH-1:0] z_out;
    logic [AWIDTH-1:0] addr_out;
    logic              clear_done_out;
`ifdef DEPTH_TEST_STATS_EN
    logic [31:0]       pass_count_out;
    logic [31:0]       fail_count_out;

    modport master (
        output valid_in, hcount_in, vcount_in, z_in, addr_in,
        output clear_in, ready_in,
        input  ready_out, valid_out, hcount_out, vcount_out,
        input  z_out, addr_out, clear_done_out,
        input  pass_count_out, fail_count_out
    );
    modport slave (
        input  valid_in, hcount_in, vcount_in, z_in, addr_in,
        input  clear_in, ready_in,
        output ready_out, valid_out, hcount_out, vcount_out,
        output z_out, addr_out, clear_done_out,
        output pass_count_out, fail_count_out
    );
`else
    modport master (
        output valid_in, hcount_in, vcount_in, z_in, addr_in,
        output clear_in, ready_in,
        input  ready_out, valid_out, hcount_out, vcount_out,
        input  z_out, addr_out, clear_done_out
    );
    modport slave (
        input  valid_in, hcount_in, vcount_in, z_in, addr_in,
        input  clear_in, ready_in,
        output ready_out, valid_out, hcount_out, vcount_out,
        output z_out, addr_out, clear_done_out
    );
`endif
endinterface

// File: rtl/depth_ram.sv
// Simple dual-port read-first depth store; the read data arrives two
// enabled cycles after the address is presented.
module depth_ram #(
    parameter int DW    = 16,
    parameter int DEPTH = 57600,
    parameter int AW    = 16
) (
    input  logic          clk_in,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_q1;
    logic [DW-1:0] r_q2;

    always_ff @(posedge clk_in) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) begin
            r_q1 <= r_mem[i_raddr];
            r_q2 <= r_q1;
        end
    end

    assign o_rdata = r_q2;
endmodule

// File: rtl/depth_test.sv
// Three-stage z-buffer test with write forwarding and a clear sweep.
// DEPTH_TEST_STATS_EN adds saturating pass/fail counters.
module depth_test
    import gfx_pkg::*;
#(
    parameter int FB_HRES = 320,
    parameter int FB_VRES = 180,
    parameter int ZWIDTH  = 16
) (
    input logic         clk_in,
    input logic         rst_in,
    depth_test_if.slave bus
);
    localparam int HWIDTH = f_hwidth(FB_HRES);
    localparam int VWIDTH = f_vwidth(FB_VRES);
    localparam int AWIDTH = f_awidth(FB_HRES, FB_VRES);
    localparam int NPIX   = FB_HRES * FB_VRES;
    localparam logic [AWIDTH-1:0] LAST   = AWIDTH'(NPIX - 1);
    localparam logic [ZWIDTH-1:0] ZFAR_Z = ZFAR[ZWIDTH-1:0];

    state_e            r_state, w_next;
    logic [AWIDTH-1:0] r_sweep;
    logic              w_clr_done;
    logic              w_adv, w_accept, w_pass, w_commit;

    logic              r_s1_vld, r_s2_vld, r_s3_vld;
    logic [HWIDTH-1:0] r_s1_hc, r_s2_hc, r_s3_hc;
    logic [VWIDTH-1:0] r_s1_vc, r_s2_vc, r_s3_vc;
    logic [ZWIDTH-1:0] r_s1_z, r_s2_z, r_s3_z;
    logic [AWIDTH-1:0] r_s1_a, r_s2_a, r_s3_a;

    logic              r_h0_vld, r_h1_vld;
    logic [AWIDTH-1:0] r_h0_a, r_h1_a;
    logic [ZWIDTH-1:0] r_h0_z, r_h1_z;
    logic [ZWIDTH-1:0] w_rd, w_zeff;

    logic              w_we;
    logic [AWIDTH-1:0] w_waddr;
    logic [ZWIDTH-1:0] w_wdata;

    assign w_adv    = bus.ready_in;
    assign w_accept = bus.valid_in && bus.ready_out;

    // Commits younger than the BRAM read are only visible in the history
    always_comb begin
        w_zeff = w_rd;
        if (r_h1_vld && r_h1_a == r_s2_a) w_zeff = r_h1_z;
        if (r_h0_vld && r_h0_a == r_s2_a) w_zeff = r_h0_z;
    end

    assign w_pass   = r_s2_z < w_zeff;
    assign w_commit = r_s2_vld && w_pass && w_adv;

    always_comb begin
        w_we    = w_commit;
        w_waddr = r_s2_a;
        w_wdata = r_s2_z;
        if (r_state == ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_sweep;
            w_wdata = ZFAR_Z;
        end
    end

    depth_ram #(
        .DW    (ZWIDTH),
        .DEPTH (NPIX),
        .AW    (AWIDTH)
    ) u_ram (
        .clk_in  (clk_in),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_adv),
        .i_raddr (bus.addr_in),
        .o_rdata (w_rd)
    );

    always_comb begin
        w_next     = r_state;
        w_clr_done = 1'b0;
        unique case (r_state)
            ST_CLEAR: begin
                if (r_sweep == LAST) begin
                    w_next     = ST_RUN;
                    w_clr_done = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.clear_in) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!r_s1_vld && !r_s2_vld && !r_s3_vld) w_next = ST_CLEAR;
            end
            default: w_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_CLEAR;
            r_sweep <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_CLEAR && r_sweep != LAST)
                r_sweep <= r_sweep + AWIDTH'(1);
            else
                r_sweep <= '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_s1_vld <= 1'b0; r_s2_vld <= 1'b0; r_s3_vld <= 1'b0;
            r_s1_hc  <= '0;   r_s2_hc  <= '0;   r_s3_hc  <= '0;
            r_s1_vc  <= '0;   r_s2_vc  <= '0;   r_s3_vc  <= '0;
            r_s1_z   <= '0;   r_s2_z   <= '0;   r_s3_z   <= '0;
            r_s1_a   <= '0;   r_s2_a   <= '0;   r_s3_a   <= '0;
        end else if (w_adv) begin
            r_s1_vld <= w_accept;
            r_s1_hc  <= bus.hcount_in;
            r_s1_vc  <= bus.vcount_in;
            r_s1_z   <= bus.z_in;
            r_s1_a   <= bus.addr_in;
            r_s2_vld <= r_s1_vld;
            r_s2_hc  <= r_s1_hc;
            r_s2_vc  <= r_s1_vc;
            r_s2_z   <= r_s1_z;
            r_s2_a   <= r_s1_a;
            r_s3_vld <= r_s2_vld && w_pass;
            r_s3_hc  <= r_s2_hc;
            r_s3_vc  <= r_s2_vc;
            r_s3_z   <= r_s2_z;
            r_s3_a   <= r_s2_a;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || w_clr_done) begin
            r_h0_vld <= 1'b0;
            r_h1_vld <= 1'b0;
            r_h0_a   <= '0;
            r_h1_a   <= '0;
            r_h0_z   <= '0;
            r_h1_z   <= '0;
        end else if (w_commit) begin
            r_h1_vld <= r_h0_vld;
            r_h1_a   <= r_h0_a;
            r_h1_z   <= r_h0_z;
            r_h0_vld <= 1'b1;
            r_h0_a   <= r_s2_a;
            r_h0_z   <= r_s2_z;
        end
    end

`ifdef DEPTH_TEST_STATS_EN
    logic [31:0] r_pass_cnt, r_fail_cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in || (r_state == ST_DRAIN && w_next == ST_CLEAR)) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else if (r_s2_vld && w_adv) begin
            if (w_pass && r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 32'd1;
            if (!w_pass && r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 32'd1;
        end
    end

    assign bus.pass_count_out = r_pass_cnt;
    assign bus.fail_count_out = r_fail_cnt;
`endif

    assign bus.ready_out      = (r_state == ST_RUN) && bus.ready_in;
    assign bus.valid_out      = r_s3_vld;
    assign bus.hcount_out     = r_s3_hc;
    assign bus.vcount_out     = r_s3_vc;
    assign bus.z_out          = r_s3_z;
    assign bus.addr_out       = r_s3_a;
    assign bus.clear_done_out = w_clr_done;
endmodule

// File: tb/tb_depth_test.sv
// Scoreboard bench for depth_test on a reduced framebuffer so two full
// clear sweeps fit a short run; the z-buffer model is a plain array.
module tb_depth_test;
    localparam int HRES = 40;
    localparam int VRES = 24;
    localparam int ZW   = 16;
    localparam int NPIX = HRES * VRES;
    localparam int HW   = $clog2(HRES);
    localparam int VW   = $clog2(VRES);
    localparam int AW   = $clog2(NPIX);

    typedef struct packed {
        logic [AW-1:0] a;
        logic [HW-1:0] h;
        logic [VW-1:0] v;
        logic [ZW-1:0] z;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    int   unsigned zbuf [NPIX];
    pix_t exp_q [$];

    depth_test_if #(.FB_HRES(HRES), .FB_VRES(VRES), .ZWIDTH(ZW)) bus ();

    depth_test #(
        .FB_HRES (HRES),
        .FB_VRES (VRES),
        .ZWIDTH  (ZW)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NPIX; i++) zbuf[i] = 32'hFFFF;
    endtask

    // Monitor: frozen-output hold, scoreboard pop, and model update on accept
    logic prev_v = 1'b0;
    logic prev_r = 1'b1;
    pix_t prev_p;
    always @(negedge clk) begin
        pix_t cur, e;
        cur = '{a: bus.addr_out, h: bus.hcount_out,
                v: bus.vcount_out, z: bus.z_out};
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r)
                chk("hold_while_frozen", {bus.valid_out, cur}, {1'b1, prev_p});
            if (bus.valid_out && bus.ready_in) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'(cur), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("output_pixel", 64'(cur), 64'(e));
                end
            end
            if (bus.valid_in && bus.ready_out) begin
                if (int'(bus.z_in) < zbuf[bus.addr_in]) begin
                    zbuf[bus.addr_in] = bus.z_in;
                    exp_q.push_back('{a: bus.addr_in, h: bus.hcount_in,
                                      v: bus.vcount_in, z: bus.z_in});
                end
            end
            prev_v = bus.valid_out;
            prev_r = bus.ready_in;
            prev_p = cur;
        end
    end

    task automatic drive(input int a, input int z, input logic vld,
                         input logic clr);
        bus.valid_in  = vld;
        bus.addr_in   = AW'(a);
        bus.hcount_in = HW'(a % HRES);
        bus.vcount_in = VW'(a / HRES);
        bus.z_in      = ZW'(z);
        bus.clear_in  = clr;
    endtask

    task automatic send(input int a, input int z, input logic clr);
        drive(a, z, 1'b1, clr);
        @(posedge clk);
        #1 drive(0, 0, 1'b0, 1'b0);
    endtask

    // Counts not-ready cycles and done pulses; pokes clear_in mid-sweep
    task automatic wait_ready(output int cyc, output int pulses);
        cyc = 0;
        pulses = 0;
        forever begin
            @(negedge clk);
            bus.clear_in = (cyc == 5);
            if (bus.ready_out) break;
            if (bus.clear_done_out) pulses++;
            cyc++;
            if (cyc > 3 * NPIX) begin
                chk("ready_timeout", 64'(cyc), 64'(NPIX));
                break;
            end
        end
        bus.clear_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        bus.ready_in = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        #1 chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int cyc, pulses, base, lat;
        bus.ready_in = 1'b1;
        drive(0, 0, 1'b0, 1'b0);
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_ready_out", 64'(bus.ready_out), 64'd0);
        chk("reset_valid_out", 64'(bus.valid_out), 64'd0);
        chk("reset_clear_done", 64'(bus.clear_done_out), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_ready(cyc, pulses);
        chk("reset_sweep_len", 64'(cyc), 64'(NPIX));
        chk("reset_done_pulses", 64'(pulses), 64'd1);

        // Same address, spaced: closer passes twice, farther is dropped
        base = n_out;
        send(100, 'h4000, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.valid_out && lat < 20);
        chk("latency", 64'(lat), 64'd3);
        @(posedge clk);
        #1 repeat (10) @(posedge clk);
        #1 send(100, 'h2000, 1'b0);
        repeat (10) @(posedge clk);
        #1 send(100, 'h3000, 1'b0);
        drain();
        chk("spaced_outputs", 64'(n_out - base), 64'd2);
`ifdef DEPTH_TEST_STATS_EN
        chk("pass_count", 64'(bus.pass_count_out), 64'd2);
        chk("fail_count", 64'(bus.fail_count_out), 64'd1);
`endif

        // Back-to-back hazard on one address
        base = n_out;
        send(5, 'h8000, 1'b0);
        send(5, 'h7000, 1'b0);
        send(5, 'h7800, 1'b0);
        drain();
        chk("forward_outputs", 64'(n_out - base), 64'd2);

        // Three in flight, output frozen for five cycles
        base = n_out;
        send(300, 'h1000, 1'b0);
        send(301, 'h1100, 1'b0);
        send(302, 'h1200, 1'b0);
        bus.ready_in = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("frozen_valid", 64'(bus.valid_out), 64'd1);
        drain();
        chk("freeze_outputs", 64'(n_out - base), 64'd3);

        // Clear with pixels in flight, last pixel shares the clear cycle
        base = n_out;
        send(200, 'h1000, 1'b0);
        send(201, 'h1100, 1'b0);
        send(202, 'h1200, 1'b1);
        wait_ready(cyc, pulses);
        chk("inflight_before_clear", 64'(n_out - base), 64'd3);
        chk("clear_sweep_min", 64'(cyc >= NPIX), 64'd1);
        chk("clear_sweep_max", 64'(cyc <= NPIX + 8), 64'd1);
        chk("clear_done_pulses", 64'(pulses), 64'd1);
        model_clear();
        base = n_out;
        send(100, 'hFFFE, 1'b0);
        drain();
        chk("after_clear_pass", 64'(n_out - base), 64'd1);

        // Random traffic on a few hot addresses with random back-pressure
        for (int i = 0; i < 600; i++) begin
            bus.ready_in = ($urandom_range(0, 9) < 8);
            drive($urandom_range(0, 7), $urandom_range(0, 'hFFFF),
                  ($urandom_range(0, 9) < 6), 1'b0);
            @(posedge clk);
            #1;
        end
        drive(0, 0, 1'b0, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
